// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtract controller:
// state encoding and the bit-counter width helper.
package sub_ctrl_pkg;

  // Raw state codes. Code 2'd3 is unused and steers the FSM back to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Bits needed to count 0..w-1. The counter is never narrower than one bit.
  function automatic int cnt_width(input int w);
    int n;
    n = $clog2(w);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between the operand registers and the subtract
// controller.
//
// Handshake: the master raises start together with a/b. The request is
// taken on any rising edge where start=1 and busy=0, and a/b are captured
// on that edge. start seen while busy=1 is dropped, not queued. done is a
// one-cycle strobe, and diff/borrow/ovf are valid from that cycle until
// the next completion.
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  import sub_ctrl_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  state_e           dbg_state;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, dbg_state
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, dbg_state
  );

endinterface

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: d = x - y - bin, with the borrow going out.
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_xy;

  // Propagate term shared by the difference and the borrow.
  always_comb begin
    w_xy = x ^ y;
    d    = w_xy ^ bin;
    bout = (~w_xy & bin) | (~x & y);
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract controller. A single sub_bit_cell is time-shared
// over the operands, LSB first, with the borrow carried in a flop. Results
// appear with a one-cycle done strobe WIDTH+1 cycles after an accepted start.
module serial_sub_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_wr;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_d;
  logic             w_bo;
  logic             w_last;

  // The cell always looks at the current low bits and the carried borrow.
  sub_bit_cell u_cell (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_last = (r_cnt == LAST_BIT);

  // Sequencing FSM plus datapath registers; all outputs come from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_wr     <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new start just like IDLE, giving back-to-back runs.
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        RUN: begin
          r_wr  <= {w_d, r_wr[WIDTH-1:1]};
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // w_d is the result MSB here, which is all the overflow rule needs.
            r_diff   <= {w_d, r_wr[WIDTH-1:1]};
            r_borrow <= w_bo;
            r_ovf    <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: an 8-bit and a 16-bit instance, a cycle-level
// reference model and directed plus random stimulus.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Clock block
  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_sub_ctrl_if #(.WIDTH(16)) bus16 ();

  serial_sub_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int          W[2] = '{8, 16};

  logic        d_start[2] = '{1'b0, 1'b0};
  logic [31:0] d_a[2]     = '{32'd0, 32'd0};
  logic [31:0] d_b[2]     = '{32'd0, 32'd0};

  assign bus8.start  = d_start[0];
  assign bus8.a      = d_a[0][7:0];
  assign bus8.b      = d_b[0][7:0];
  assign bus16.start = d_start[1];
  assign bus16.a     = d_a[1][15:0];
  assign bus16.b     = d_b[1][15:0];

  logic        o_busy[2];
  logic        o_done[2];
  logic        o_borrow[2];
  logic        o_ovf[2];
  logic [31:0] o_diff[2];

  assign o_busy[0]   = bus8.busy;
  assign o_done[0]   = bus8.done;
  assign o_borrow[0] = bus8.borrow;
  assign o_ovf[0]    = bus8.ovf;
  assign o_diff[0]   = {24'd0, bus8.diff};
  assign o_busy[1]   = bus16.busy;
  assign o_done[1]   = bus16.done;
  assign o_borrow[1] = bus16.borrow;
  assign o_ovf[1]    = bus16.ovf;
  assign o_diff[1]   = {16'd0, bus16.diff};

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Arithmetic reference
  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_diff(input int w, input logic [31:0] a, input logic [31:0] b);
    return (a - b) & wmask(w);
  endfunction

  function automatic logic ref_borrow(input int w, input logic [31:0] a, input logic [31:0] b);
    return (a & wmask(w)) < (b & wmask(w));
  endfunction

  function automatic logic ref_ovf(input int w, input logic [31:0] a, input logic [31:0] b);
    longint lim, sa, sb, r;
    lim = longint'(1) << (w - 1);
    sa  = longint'(a & wmask(w));
    sb  = longint'(b & wmask(w));
    if (sa >= lim) sa -= 2 * lim;
    if (sb >= lim) sb -= 2 * lim;
    r = sa - sb;
    return (r >= lim) || (r < -lim);
  endfunction

  // Model: a request is taken when the unit is not busy; busy then lasts W
  // cycles and done follows in the next cycle with the arithmetic result.
  logic        e_busy[2]   = '{1'b0, 1'b0};
  logic        e_done[2]   = '{1'b0, 1'b0};
  logic        e_borrow[2] = '{1'b0, 1'b0};
  logic        e_ovf[2]    = '{1'b0, 1'b0};
  logic [31:0] e_diff[2]   = '{32'd0, 32'd0};
  logic [31:0] c_a[2]      = '{32'd0, 32'd0};
  logic [31:0] c_b[2]      = '{32'd0, 32'd0};
  int          m_left[2]   = '{0, 0};

  // Reference model advances on every rising edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e_busy[k] = 1'b0; e_done[k] = 1'b0; e_diff[k] = '0;
        e_borrow[k] = 1'b0; e_ovf[k] = 1'b0; m_left[k] = 0;
      end else if (!e_busy[k] && d_start[k]) begin
        c_a[k] = d_a[k]; c_b[k] = d_b[k];
        e_busy[k] = 1'b1; e_done[k] = 1'b0; m_left[k] = W[k] - 1;
      end else if (e_busy[k]) begin
        if (m_left[k] == 0) begin
          e_busy[k]   = 1'b0;
          e_done[k]   = 1'b1;
          e_diff[k]   = ref_diff(W[k], c_a[k], c_b[k]);
          e_borrow[k] = ref_borrow(W[k], c_a[k], c_b[k]);
          e_ovf[k]    = ref_ovf(W[k], c_a[k], c_b[k]);
        end else begin
          m_left[k]--;
        end
      end else begin
        e_done[k] = 1'b0;
      end
    end
  end

  // Compare process: every output of both instances, every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("w%0d busy", W[k]),   32'(o_busy[k]),   32'(e_busy[k]));
        check($sformatf("w%0d done", W[k]),   32'(o_done[k]),   32'(e_done[k]));
        check($sformatf("w%0d diff", W[k]),   o_diff[k],        e_diff[k]);
        check($sformatf("w%0d borrow", W[k]), 32'(o_borrow[k]), 32'(e_borrow[k]));
        check($sformatf("w%0d ovf", W[k]),    32'(o_ovf[k]),    32'(e_ovf[k]));
      end
    end
  end

  // Waits (bounded) for done, counting busy cycles; returns at done's falling edge.
  task automatic wait_done(input int k, output int nb, output bit got);
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_busy[k]) nb++;
      if (o_done[k]) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Driver: one start pulse, operands scrambled right after acceptance.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input bit lit, input logic [31:0] xd, input logic xb, input logic xo);
    int nb;
    bit got;
    @(posedge clk); #1;
    d_start[k] = 1'b1; d_a[k] = a; d_b[k] = b;
    @(posedge clk); #1;
    d_start[k] = 1'b0;
    d_a[k] = $urandom & wmask(W[k]);
    d_b[k] = $urandom & wmask(W[k]);
    wait_done(k, nb, got);
    check("done_seen", 32'(got), 32'd1);
    if (lit) begin
      check("busy_cycles", 32'(nb), 32'(W[k]));
      check("lit_diff",   o_diff[k],        xd);
      check("lit_borrow", 32'(o_borrow[k]), 32'(xb));
      check("lit_ovf",    32'(o_ovf[k]),    32'(xo));
      check("model_diff", e_diff[k],        xd);
      check("model_ovf",  32'(e_ovf[k]),    32'(xo));
    end
  endtask

  typedef struct {
    logic [31:0] a, b, d;
    logic        br, ov;
  } vec_t;

  vec_t vecs[7] = '{
    '{32'h35, 32'h12, 32'h23, 1'b0, 1'b0},
    '{32'h12, 32'h35, 32'hDD, 1'b1, 1'b0},
    '{32'h80, 32'h01, 32'h7F, 1'b0, 1'b1},
    '{32'h7F, 32'hFF, 32'h80, 1'b1, 1'b1},
    '{32'h00, 32'h00, 32'h00, 1'b0, 1'b0},
    '{32'hFF, 32'hFF, 32'h00, 1'b0, 1'b0},
    '{32'h00, 32'h01, 32'hFF, 1'b1, 1'b0}
  };

  // Main stimulus sequence and final report
  initial begin
    int  nb, cyc;
    bit  got, saw_done;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(o_busy[0]), 32'd0);
    check("rst_done", 32'(o_done[0]), 32'd0);
    check("rst_diff", o_diff[0], 32'd0);
    check("rst_borrow", 32'(o_borrow[0]), 32'd0);
    check("rst_ovf", 32'(o_ovf[0]), 32'd0);

    // Directed vectors with hand-computed results
    foreach (vecs[i])
      run_op(0, vecs[i].a, vecs[i].b, 1'b1, vecs[i].d, vecs[i].br, vecs[i].ov);

    // Start while busy is dropped; the first result is delivered untouched
    @(posedge clk); #1;
    d_start[0] = 1'b1; d_a[0] = 32'h35; d_b[0] = 32'h12;
    @(posedge clk); #1;
    d_start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d_start[0] = 1'b1; d_a[0] = 32'h99; d_b[0] = 32'h11;
    @(posedge clk); #1;
    d_start[0] = 1'b0;
    wait_done(0, nb, got);
    check("ign_done_seen", 32'(got), 32'd1);
    check("ign_diff", o_diff[0], 32'h23);

    // Start held during done: the next run begins with no idle gap
    d_start[0] = 1'b1; d_a[0] = 32'h80; d_b[0] = 32'h01;
    @(posedge clk); #1;
    d_start[0] = 1'b0;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (o_done[0]) begin
        got = 1'b1;
        break;
      end
    end
    check("b2b_done_seen", 32'(got), 32'd1);
    check("b2b_gap", 32'(cyc), 32'd9);
    check("b2b_diff", o_diff[0], 32'h7F);
    check("b2b_ovf", 32'(o_ovf[0]), 32'd1);

    // Reset in the middle of a run
    @(posedge clk); #1;
    d_start[0] = 1'b1; d_a[0] = 32'h35; d_b[0] = 32'h12;
    @(posedge clk); #1;
    d_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(o_busy[0]), 32'd0);
    check("midrst_done", 32'(o_done[0]), 32'd0);
    check("midrst_diff", o_diff[0], 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_done[0]) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    run_op(0, 32'h35, 32'h12, 1'b1, 32'h23, 1'b0, 1'b0);

    // Random regression on both widths, checked by the model
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 1000; n++) begin
        run_op(k, $urandom & wmask(W[k]), $urandom & wmask(W[k]),
               1'b0, 32'd0, 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtract controller. It sequences a single 1-bit full-subtractor cell over two WIDTH-bit operands, one bit per clock, LSB first. A flip-flop carries the borrow between bits. The block accepts a start pulse, runs for WIDTH cycles, then presents the difference, the unsigned borrow and the signed overflow with a one-cycle done strobe. It is the area-minimal subtract unit for the lab datapath and sits between the operand registers and the result display logic.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle strobe; results valid from this cycle
- diff  output  WIDTH  a − b modulo 2^WIDTH
- borrow  output  1  final borrow-out; 1 iff a < b unsigned
- ovf  output  1  signed overflow of a − b (two's complement)

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: busy=0, done=0. On start=1, the block:
  - loads shift registers sa←a and sb←b,
  - clears the borrow flop and the bit counter,
  - goes to RUN.
- RUN: busy=1. Each cycle the cell computes:
  - d = sa[0] ^ sb[0] ^ br
  - bo = (~(sa[0]^sb[0]) & br) | (~sa[0] & sb[0])
- RUN register updates, every RUN cycle:
  - d shifts into the MSB of the work register wr (wr shifts right);
  - sa and sb shift right;
  - br←bo; counter increments.
- RUN exit: when the counter reaches WIDTH−1 (last bit), the same edge performs these loads, then the FSM goes to DONE:
  - diff←{d, wr[WIDTH-1:1]}
  - borrow←bo
  - ovf←(a_msb ^ b_msb) & (d ^ a_msb), where a_msb and b_msb are the captured operand MSBs, held in dedicated flops.
- DONE: done=1, busy=0. Start is accepted exactly as in IDLE (back-to-back operation). Otherwise the next state is IDLE.
- start while busy=1 is ignored; it is not queued.
- diff, borrow and ovf change only at the completing edge. They hold their value through later IDLE cycles and through the next RUN, until the next completion.
- Reset (any state, including mid-RUN):
  - state→IDLE; busy, done, diff, borrow and ovf all →0;
  - the in-flight operation is discarded and no done is produced.

## Timing
- Start sampled high at edge E0. busy=1 in the cycles after edges E0..E(WIDTH−1). done=1 in the single cycle after edge E(WIDTH); results are visible in that same cycle.
- Latency from accepted start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+1 cycles when start is asserted during DONE.
- a and b need only be stable in the start cycle.
- Reset values: busy=0, done=0, diff=0, borrow=0, ovf=0, state=IDLE.

## Structure
- Shared package sub_ctrl_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the counter-width function (clog2(WIDTH)).
- Encoding 2'd3 is illegal and recovers to IDLE.
- One natural sub-module: sub_bit_cell, a purely combinational 1-bit full subtractor (inputs x, y, bin; outputs d, bout) using the equations above. It is instantiated once. All state lives in serial_sub_ctrl.

## Test plan
- WIDTH=8, a=0x35, b=0x12, start at E0 -> done in cycle after E8; diff=0x23, borrow=0, ovf=0; busy high exactly 8 cycles.
- a=0x12, b=0x35 -> diff=0xDD, borrow=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- Corners, each checked for borrow=0, ovf=0:
  - a=b=0x00 -> diff=0x00;
  - a=b=0xFF -> diff=0x00;
  - a=0x00, b=0x01 -> diff=0xFF, borrow=1.
- Pulse start again at E3 with different operands -> ignored; first result 0x23 delivered unchanged. Then start held high during the done cycle -> second operation begins with no IDLE gap, and its done follows 9 cycles later.
- Reset asserted at E4 of a run -> next cycle busy=0, done=0, diff=0. No done strobe follows. A fresh start then completes normally.
- Random regression: 1000 random a/b pairs, WIDTH=8 and WIDTH=16, against the reference model (a−b) mod 2^WIDTH, a<b and the signed overflow rule.
